// File: rtl/calc_pkg.sv
// Shared key codes, sequencer states and operator encodings for the calculator control unit.
package calc_pkg;

  localparam logic [3:0] BTN_DIGIT_MAX = 4'h9;
  localparam logic [3:0] BTN_ADD       = 4'hA;
  localparam logic [3:0] BTN_SUB       = 4'hB;
  localparam logic [3:0] BTN_MUL       = 4'hC;
  localparam logic [3:0] BTN_DIV       = 4'hD;
  localparam logic [3:0] BTN_EQUAL     = 4'hE;
  localparam logic [3:0] BTN_CLEAR     = 4'hF;

  typedef enum logic [2:0] {
    ST_ENTRY_A  = 3'd0,
    ST_OP_PEND  = 3'd1,
    ST_ENTRY_B  = 3'd2,
    ST_DIVIDING = 3'd3,
    ST_RESULT   = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  function automatic op_t btn_to_op(input logic [3:0] btn);
    op_t op;
    case (btn)
      BTN_SUB: op = OP_SUB;
      BTN_MUL: op = OP_MUL;
      BTN_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, DATA_WIDTH cycles per divide.
module calc_divider
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic                  busy_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] rem_r;
  logic [DATA_WIDTH-1:0] quo_r;
  logic [DATA_WIDTH-1:0] dsr_r;
  logic [DATA_WIDTH:0]   shifted_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic                  fits_s;
  logic [DATA_WIDTH-1:0] next_rem_s;
  logic [DATA_WIDTH-1:0] next_quo_s;

  // One restoring step; done/quotient expose the final step so the caller can latch it on the same edge
  always_comb begin
    shifted_s = {rem_r, quo_r[DATA_WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dsr_r};
    fits_s    = (shifted_s >= {1'b0, dsr_r});
    if (fits_s) begin
      next_rem_s = diff_s[DATA_WIDTH-1:0];
    end else begin
      next_rem_s = shifted_s[DATA_WIDTH-1:0];
    end
    next_quo_s = {quo_r[DATA_WIDTH-2:0], fits_s};
    done       = busy_r && (count_r == LAST) && !abort;
    quotient   = next_quo_s;
  end

  // Iteration state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_r  <= 1'b0;
      count_r <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      dsr_r   <= '0;
    end else if (abort) begin
      busy_r  <= 1'b0;
      count_r <= '0;
    end else if (start) begin
      busy_r  <= 1'b1;
      count_r <= '0;
      rem_r   <= '0;
      quo_r   <= dividend;
      dsr_r   <= divisor;
    end else if (busy_r) begin
      rem_r   <= next_rem_s;
      quo_r   <= next_quo_s;
      count_r <= count_r + CW'(1);
      if (count_r == LAST) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control unit: keypad press decoding, operand entry, operator chaining and display.
// Define CALC_MUL_EN to build the multiplier; otherwise BTN_MUL is ignored everywhere.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            button,
  input  logic                  is_pressed_next,
  output logic [DATA_WIDTH-1:0] display,
  output logic                  busy,
  output logic                  error,
  output logic                  overflow
);

  localparam int DCW = $clog2(MAX_DIGITS + 1);
  localparam int EW  = DATA_WIDTH + 4;
  localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

  state_t                state_r;
  op_t                   op_r;
  op_t                   pend_op_r;
  logic                  chain_r;
  logic                  prev_r;
  logic [DATA_WIDTH-1:0] display_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DCW-1:0]        digits_r;
  logic                  error_r;
  logic                  overflow_r;

  logic                  press_s;
  logic                  is_digit_s;
  logic                  is_op_s;
  logic                  is_equal_s;
  logic                  is_clear_s;
  op_t                   key_op_s;
  logic [DATA_WIDTH-1:0] digit_val_s;
  logic [EW-1:0]         entry_val_s;
  logic                  entry_ok_s;
  logic [DATA_WIDTH:0]   sum_s;
  logic [DATA_WIDTH-1:0] eval_res_s;
  logic                  eval_ovf_s;
  logic                  div_start_s;
  logic                  div_busy_s;
  logic                  div_done_s;
  logic [DATA_WIDTH-1:0] div_quo_s;
`ifdef CALC_MUL_EN
  logic [2*DATA_WIDTH-1:0] prod_s;
`endif

  // Key decode and digit accumulation
  always_comb begin
    press_s     = is_pressed_next & ~prev_r;
    is_digit_s  = press_s && (button <= BTN_DIGIT_MAX);
    is_equal_s  = press_s && (button == BTN_EQUAL);
    is_clear_s  = press_s && (button == BTN_CLEAR);
    key_op_s    = btn_to_op(button);
    case (button)
      BTN_ADD, BTN_SUB, BTN_DIV: is_op_s = press_s;
`ifdef CALC_MUL_EN
      BTN_MUL:                   is_op_s = press_s;
`endif
      default:                   is_op_s = 1'b0;
    endcase
    digit_val_s = {{(DATA_WIDTH-4){1'b0}}, button};
    entry_val_s = ({4'h0, display_r} * EW'(10)) + {4'h0, digit_val_s};
    entry_ok_s  = (digits_r < DCW'(MAX_DIGITS)) && (entry_val_s[EW-1:DATA_WIDTH] == 4'h0);
    div_start_s = (state_r == ST_ENTRY_B) && (is_op_s || is_equal_s) &&
                  (op_r == OP_DIV) && (display_r != ZERO);
  end

  // Single-cycle arithmetic on A (a_r) and B (display_r)
  always_comb begin
    sum_s      = {1'b0, a_r} + {1'b0, display_r};
    eval_res_s = ZERO;
    eval_ovf_s = 1'b0;
`ifdef CALC_MUL_EN
    prod_s     = {ZERO, a_r} * {ZERO, display_r};
`endif
    case (op_r)
      OP_ADD: begin
        eval_res_s = sum_s[DATA_WIDTH-1:0];
        eval_ovf_s = sum_s[DATA_WIDTH];
      end
      OP_SUB: begin
        eval_res_s = a_r - display_r;
        eval_ovf_s = (a_r < display_r);
      end
`ifdef CALC_MUL_EN
      OP_MUL: begin
        eval_res_s = prod_s[DATA_WIDTH-1:0];
        eval_ovf_s = (prod_s[2*DATA_WIDTH-1:DATA_WIDTH] != ZERO);
      end
`endif
      default: begin
        eval_res_s = ZERO;
        eval_ovf_s = 1'b0;
      end
    endcase
  end

  calc_divider #(.DATA_WIDTH(DATA_WIDTH)) u_divider (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start_s),
    .abort    (is_clear_s),
    .dividend (a_r),
    .divisor  (display_r),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (div_quo_s)
  );

  // Sequencer FSM; CLEAR takes priority over everything, including a finishing divide
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_ENTRY_A;
      op_r       <= OP_ADD;
      pend_op_r  <= OP_ADD;
      chain_r    <= 1'b0;
      prev_r     <= 1'b0;
      display_r  <= ZERO;
      a_r        <= ZERO;
      digits_r   <= '0;
      error_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      prev_r <= is_pressed_next;
      if (is_clear_s) begin
        state_r    <= ST_ENTRY_A;
        op_r       <= OP_ADD;
        pend_op_r  <= OP_ADD;
        chain_r    <= 1'b0;
        display_r  <= ZERO;
        a_r        <= ZERO;
        digits_r   <= '0;
        error_r    <= 1'b0;
        overflow_r <= 1'b0;
      end else begin
        case (state_r)
          ST_ENTRY_A, ST_RESULT: begin
            if (is_digit_s) begin
              if (state_r == ST_RESULT) begin
                display_r <= digit_val_s;
                digits_r  <= DCW'(1);
                state_r   <= ST_ENTRY_A;
              end else if (entry_ok_s) begin
                display_r <= entry_val_s[DATA_WIDTH-1:0];
                digits_r  <= digits_r + DCW'(1);
              end
            end else if (is_op_s) begin
              a_r     <= display_r;
              op_r    <= key_op_s;
              state_r <= ST_OP_PEND;
            end
          end
          ST_OP_PEND: begin
            if (is_digit_s) begin
              display_r <= digit_val_s;
              digits_r  <= DCW'(1);
              state_r   <= ST_ENTRY_B;
            end else if (is_op_s) begin
              op_r <= key_op_s;
            end
          end
          ST_ENTRY_B: begin
            if (is_digit_s) begin
              if (entry_ok_s) begin
                display_r <= entry_val_s[DATA_WIDTH-1:0];
                digits_r  <= digits_r + DCW'(1);
              end
            end else if (is_op_s || is_equal_s) begin
              digits_r <= '0;
              if (op_r == OP_DIV) begin
                overflow_r <= 1'b0;
                if (display_r == ZERO) begin
                  state_r   <= ST_ERROR;
                  error_r   <= 1'b1;
                  display_r <= ALL_ONES;
                end else begin
                  state_r   <= ST_DIVIDING;
                  chain_r   <= is_op_s;
                  pend_op_r <= key_op_s;
                end
              end else begin
                display_r  <= eval_res_s;
                a_r        <= eval_res_s;
                overflow_r <= eval_ovf_s;
                if (is_op_s) begin
                  op_r    <= key_op_s;
                  state_r <= ST_OP_PEND;
                end else begin
                  state_r <= ST_RESULT;
                end
              end
            end
          end
          ST_DIVIDING: begin
            if (div_done_s) begin
              display_r <= div_quo_s;
              a_r       <= div_quo_s;
              if (chain_r) begin
                op_r    <= pend_op_r;
                state_r <= ST_OP_PEND;
              end else begin
                state_r <= ST_RESULT;
              end
            end
          end
          ST_ERROR: begin
            state_r <= ST_ERROR;
          end
          default: begin
            state_r <= ST_ENTRY_A;
          end
        endcase
      end
    end
  end

  assign display  = display_r;
  assign busy     = div_busy_s;
  assign error    = error_r;
  assign overflow = overflow_r;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Parametrised second-generation calculator control unit. Consumes keypad codes qualified by `is_pressed_next`, assembles multi-digit decimal operands, chains operators, and drives the display value. Adds subtraction, multiplication, an iterative multi-cycle divider with busy/error reporting, and overflow detection. Sits between the keypad debouncer and the display driver.

## Interface
- `DATA_WIDTH`, 16: operand/result width in bits; unsigned; minimum 8.
- `MAX_DIGITS`, 4: maximum decimal digits accepted per operand.
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `button` in 4: key code. Digits are 4'h0–4'h9; `BTN_ADD` = 4'hA, `BTN_SUB` = 4'hB, `BTN_MUL` = 4'hC, `BTN_DIV` = 4'hD, `BTN_EQUAL` = 4'hE, `BTN_CLEAR` = 4'hF.
- `is_pressed_next` in 1: key-valid level. A press is its 0→1 transition; `button` is sampled in that cycle.
- `display` out DATA_WIDTH: current operand or result.
- `busy` out 1: divider running.
- `error` out 1: divide-by-zero latched.
- `overflow` out 1: last operation wrapped.

## Operation
- Press detection: a registered copy of `is_pressed_next` gives `press = is_pressed_next & ~prev`. Holding the level for several cycles counts as one press.
- States:
  - ENTRY_A: digits build operand A.
  - OP_PEND: an operator is stored and no B digit has been entered yet.
  - ENTRY_B: digits build operand B.
  - DIVIDING: divider active.
  - RESULT: result shown.
  - ERROR: divide-by-zero.
- Digit in ENTRY_A or ENTRY_B: `acc = acc*10 + d`. The digit is ignored if the digit count is already MAX_DIGITS or the new value would exceed 2^DATA_WIDTH−1.
- Digit in OP_PEND: go to ENTRY_B with `acc = d`.
- Digit in RESULT: go to ENTRY_A with `acc = d`.
- Operator in ENTRY_A or RESULT: A = display; store the operator; go to OP_PEND.
- Operator in OP_PEND: replace the stored operator.
- Operator in ENTRY_B (chaining): evaluate A op B. The result becomes the new A, the new operator is stored, and the state goes to OP_PEND. If the pending operation is a divide, the new operator is held until the divide completes.
- EQUAL in ENTRY_B: evaluate A op B, then go to RESULT.
- EQUAL in any other state: no effect.
- CLEAR in any state (including DIVIDING and ERROR): display, A, B, operator, flags and digit count go to 0; abort the divider; go to ENTRY_A.
- In ERROR, every key except CLEAR is ignored.
- Presses other than CLEAR during DIVIDING are dropped.
- Arithmetic is unsigned, modulo 2^DATA_WIDTH:
  - Subtract underflow sets `overflow`.
  - An add carry-out sets `overflow`.
  - A multiply whose upper DATA_WIDTH product bits are non-zero sets `overflow`.
  - `overflow` clears on the next evaluation or CLEAR.
- Divide returns the truncated quotient.
- Divide by zero: enter ERROR with `error` = 1 and `display` = all ones.

## Timing
- Reset values: `display` = 0, `busy` = 0, `error` = 0, `overflow` = 0, state ENTRY_A.
- Press edge in cycle N:
  - digit, add, sub, mul, operator store and CLEAR take effect in `display` and the flags at cycle N+1;
  - divide: `busy` = 1 from N+1 to N+DATA_WIDTH; the quotient appears on `display` and `busy` falls at N+DATA_WIDTH+1;
  - divide-by-zero is detected without iterating: ERROR at N+1, `busy` stays 0.
- A CLEAR edge coincident with the final divider cycle wins; no result is written.
- Reset asserted mid-divide clears everything immediately.
- Multiple rising edges are never merged. The minimum press spacing is 2 cycles (high then low).

## Configuration
- `CALC_MUL_EN` defined: multiplier present; `BTN_MUL` behaves as an operator.
- `CALC_MUL_EN` undefined: no multiplier hardware; `BTN_MUL` is ignored in all states and `overflow` never reflects a multiply.

## Structure
- `calc_pkg` holds the button-code constants (`BTN_*`), the state enum, and the operator enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
- One sub-module, `calc_divider`: restoring divider, one quotient bit per cycle, parametrised by DATA_WIDTH.
  - Ports: `start`, `abort`, `dividend`, `divisor`, `busy`, `done`, `quotient`.
- Press edge detect, digit accumulator, FSM and add/sub/mul stay in `calc_sequencer`.

## Test plan
- Press 8, then 9 → `display` = 89.
- CLEAR, press 3, then hold `BTN_ADD` for 2 cycles (counts as one press), press 2, EQUAL → `display` = 5, `overflow` = 0.
- CLEAR, 7, DIV, 4, EQUAL → `busy` high for 16 cycles, then `display` = 1. Then ADD, 7, EQUAL → `display` = 8.
- CLEAR, 5, DIV, 0, EQUAL → `error` = 1, `display` = 16'hFFFF, the next digit is ignored; CLEAR → `display` = 0, `error` = 0.
- Digit overflow: press 9 five times with MAX_DIGITS = 4 → `display` = 9999. Chaining: 2, SUB, 3, ADD → `display` = 65535, `overflow` = 1.
- Start 9, DIV, 3, EQUAL and press CLEAR mid-divide → `busy` drops next cycle, `display` = 0. Without `CALC_MUL_EN`: 6, MUL, 2, EQUAL → `display` = 62.
